// File: rtl/mac_defs.sv
// mac_defs: shared FSM state encodings and width helpers for the MAC accumulate tile
package mac_defs;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  function automatic int clog2_1(input int x);
    return x > 1 ? $clog2(x) : 1;
  endfunction
  function automatic int acc_width(input int dw, input int k);
    return 2 * dw + clog2_1(k);
  endfunction
endpackage

// File: rtl/mac_lane.sv
// mac_lane: one C column's accumulator plus the registered result presented on c_data
module mac_lane #(
  parameter int PW = 16,
  parameter int AW = 17,
  parameter bit SIGNED = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          add,
  input  logic          last,
  input  logic [PW-1:0] prod,
  output logic [AW-1:0] acc_out
);
  logic [AW-1:0] acc, ext, sum;
  always_comb begin
    ext = {{(AW-PW){SIGNED && prod[PW-1]}}, prod};
    sum = acc + ext;
  end
  // the final term bypasses acc so the result lands in acc_out the same edge
  always_ff @(posedge clk) begin
    if (reset) begin
      acc     <= '0;
      acc_out <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (add) begin
      acc <= last ? '0 : sum;
      if (last) acc_out <= sum;
    end
  end
endmodule

// File: rtl/mac_accum_tile.sv
// mac_accum_tile: multi-lane MAC accumulate stage streaming LANES-wide C writes with backpressure
module mac_accum_tile
  import mac_defs::*;
#(
  parameter int M = 4,
  parameter int K = 4,
  parameter int N = 4,
  parameter int LANES = 2,
  parameter int DATA_WIDTH_INIT_MATRIX = 32,
  parameter bit SIGNED = 1'b0,
  parameter int ACC_WIDTH = acc_width(DATA_WIDTH_INIT_MATRIX, K)
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    start,
  input  logic                                    prod_valid,
  output logic                                    prod_ready,
  input  logic [LANES*2*DATA_WIDTH_INIT_MATRIX-1:0] prod_data,
  output logic                                    c_we,
  input  logic                                    c_ready,
  output logic [clog2_1(M)-1:0]                   c_row_addr,
  output logic [clog2_1(N)-1:0]                   c_col_addr,
  output logic [LANES*ACC_WIDTH-1:0]              c_data,
  output logic                                    busy,
  output logic                                    mac_done
);
  localparam int PW = 2 * DATA_WIDTH_INIT_MATRIX;
  localparam int KW = clog2_1(K);
  localparam int RW = clog2_1(M);
  localparam int CW = clog2_1(N);
  if (N % LANES != 0) begin : g_bad_lanes
    $error("mac_accum_tile: N must be a multiple of LANES");
  end
  logic [1:0] state;
  logic [KW-1:0] k;
  logic clr, accept, last_k, col_wrap, wr_done;
  always_comb begin
    prod_ready = state == ACCUM;
    c_we       = state == WRITE;
    busy       = state != IDLE;
    clr        = state == IDLE && start;
    accept     = prod_valid && prod_ready;
    last_k     = k == KW'(K - 1);
    col_wrap   = c_col_addr == CW'(N - LANES);
    wr_done    = c_we && c_ready;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      k          <= '0;
      c_row_addr <= '0;
      c_col_addr <= '0;
      mac_done   <= 1'b0;
    end else begin
      mac_done <= 1'b0;
      if (clr) begin
        state      <= ACCUM;
        k          <= '0;
        c_row_addr <= '0;
        c_col_addr <= '0;
      end
      if (accept) begin
        k <= last_k ? '0 : k + 1'b1;
        if (last_k) state <= WRITE;
      end
      if (wr_done) begin
        if (col_wrap && c_row_addr == RW'(M - 1)) begin
          state    <= IDLE;
          mac_done <= 1'b1;
        end else begin
          state      <= ACCUM;
          c_col_addr <= col_wrap ? '0 : c_col_addr + CW'(LANES);
          if (col_wrap) c_row_addr <= c_row_addr + 1'b1;
        end
      end
    end
  end
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    mac_lane #(.PW(PW), .AW(ACC_WIDTH), .SIGNED(SIGNED)) u_lane (
      .clk    (clk),
      .reset  (reset),
      .clr    (clr),
      .add    (accept),
      .last   (last_k),
      .prod   (prod_data[i*PW +: PW]),
      .acc_out(c_data[i*ACC_WIDTH +: ACC_WIDTH])
    );
  end
endmodule
